// File: rtl/fsm_burst_rd_oh_if.sv
// Request/strobe bundle between a burst-read requester and fsm_burst_rd_oh.
// The controller side uses the slave modport; state is a debug view of the FSM.
interface fsm_burst_rd_oh_if #(
    parameter int CNT_W = 4
);
    // Handshake: go is a request taken only while busy is low (one accepted
    // go per burst); the burst then ends with exactly one of ds (all beats
    // done), err (retry timeout) or neither (abort), followed by busy low.
    logic             go;
    logic [CNT_W-1:0] len;
    logic             ws;
    logic             abort;
    logic             rd;
    logic             ds;
    logic             err;
    logic             busy;
    logic [CNT_W-1:0] beat;
    logic [4:0]       state;

    modport master (
        output go, len, ws, abort,
        input  rd, ds, err, busy, beat, state
    );

    modport slave (
        input  go, len, ws, abort,
        output rd, ds, err, busy, beat, state
    );
endinterface

// File: rtl/fsm_burst_rd_oh.sv
// One-hot burst read controller: READ/DLY beat pairs with bounded ws retries,
// abort, and registered outputs decoded from the next state.
module fsm_burst_rd_oh #(
    parameter int CNT_W  = 4,
    parameter int MAX_WS = 7,
    parameter int RT_W   = $clog2(MAX_WS + 1)
) (
    input logic              clk,
    input logic              rst_n,
    fsm_burst_rd_oh_if.slave bus
);

    localparam int I_IDLE = 0;
    localparam int I_READ = 1;
    localparam int I_DLY  = 2;
    localparam int I_DONE = 3;
    localparam int I_ERR  = 4;

    typedef enum logic [4:0] {
        S_IDLE = 5'b00001,
        S_READ = 5'b00010,
        S_DLY  = 5'b00100,
        S_DONE = 5'b01000,
        S_ERR  = 5'b10000
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] beat_q, beat_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [RT_W-1:0]  retry_q, retry_d;
    logic             rd_q, ds_q, err_q, busy_q;
    logic             legal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            len_q   <= '0;
            retry_q <= '0;
            rd_q    <= 1'b0;
            ds_q    <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            len_q   <= len_d;
            retry_q <= retry_d;
            rd_q    <= (state_d == S_READ) || (state_d == S_DLY);
            ds_q    <= (state_d == S_DONE);
            err_q   <= (state_d == S_ERR);
            busy_q  <= (state_d != S_IDLE);
        end
    end

    always_comb begin
        state_d = S_IDLE;
        beat_d  = beat_q;
        len_d   = len_q;
        retry_d = retry_q;
        // Exactly one bit set; anything else recovers to IDLE.
        legal   = (state_q != 5'b00000) && ((state_q & (state_q - 5'd1)) == 5'b00000);

        if (!legal) begin
            state_d = S_IDLE;
        end else if (!state_q[I_IDLE] && bus.abort) begin
            state_d = S_IDLE;
        end else begin
            case (1'b1)
                state_q[I_IDLE]: begin
                    if (bus.go) begin
                        state_d = S_READ;
                        len_d   = (bus.len == '0) ? CNT_W'(1) : bus.len;
                        beat_d  = '0;
                        retry_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                state_q[I_READ]: state_d = S_DLY;
                state_q[I_DLY]: begin
                    if (bus.ws) begin
                        if (retry_q < RT_W'(MAX_WS)) begin
                            state_d = S_READ;
                            retry_d = retry_q + RT_W'(1);
                        end else begin
                            state_d = S_ERR;
                            retry_d = '0;
                        end
                    end else begin
                        beat_d  = beat_q + CNT_W'(1);
                        retry_d = '0;
                        state_d = (beat_d == len_q) ? S_DONE : S_READ;
                    end
                end
                state_q[I_DONE]: state_d = S_IDLE;
                state_q[I_ERR]:  state_d = S_IDLE;
                default:         state_d = S_IDLE;
            endcase
        end
    end

    assign bus.rd    = rd_q;
    assign bus.ds    = ds_q;
    assign bus.err   = err_q;
    assign bus.busy  = busy_q;
    assign bus.beat  = beat_q;
    assign bus.state = state_q;

endmodule

// File: tb/tb_fsm_burst_rd_oh.sv
// Randomized burst stimulus with a burst-level reference model; a monitor
// summarises each finished burst and compares it against the expected queue.
module tb_fsm_burst_rd_oh;

    localparam int CNT_W  = 4;
    localparam int MAX_WS = 2;
    localparam int W      = 22;  // {kind[1:0], beat[3:0], rd_cycles[7:0], busy_cycles[7:0]}

    localparam int K_DONE  = 0;
    localparam int K_ERR   = 1;
    localparam int K_ABORT = 2;
    localparam int K_BAD   = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fsm_burst_rd_oh_if #(.CNT_W(CNT_W)) bus ();

    fsm_burst_rd_oh #(.CNT_W(CNT_W), .MAX_WS(MAX_WS)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    logic [W-1:0] exp_q[$];
    int           vectors = 0;
    int           miscompares = 0;
    int           waits[16];

    task automatic check(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] pack(input int kind, input int bt, input int rdc, input int bc);
        return {2'(kind), 4'(bt), 8'(rdc), 8'(bc)};
    endfunction

    // Burst outcome from the rules: each beat costs a READ+DLY pair per DLY visit.
    function automatic logic [W-1:0] model(input int ln, input int ab_beat);
        int n_beats;
        int rdc;
        n_beats = (ln == 0) ? 1 : ln;
        rdc = 0;
        for (int i = 0; i < n_beats; i++) begin
            if (i == ab_beat) begin
                rdc += 2;
                return pack(K_ABORT, i, rdc, rdc);
            end
            if (waits[i] > MAX_WS) begin
                rdc += 2 * (MAX_WS + 1);
                return pack(K_ERR, i, rdc, rdc + 1);
            end
            rdc += 2 * (waits[i] + 1);
        end
        return pack(K_DONE, n_beats, rdc, rdc + 1);
    endfunction

    // ---------------- monitor / scoreboard ----------------
    bit in_b;
    int m_rd, m_busy, m_ds, m_err, m_kind;
    logic [W-1:0] m_exp, m_act;

    initial begin
        in_b = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_b = 1'b0;
                continue;
            end
            if (bus.busy && !in_b) begin
                in_b = 1'b1;
                m_rd = 0; m_busy = 0; m_ds = 0; m_err = 0;
            end
            if (in_b) begin
                if (bus.busy) begin
                    m_busy++;
                    m_rd  += int'(bus.rd);
                    m_ds  += int'(bus.ds);
                    m_err += int'(bus.err);
                end else begin
                    in_b = 1'b0;
                    if (m_ds == 1 && m_err == 0)      m_kind = K_DONE;
                    else if (m_err == 1 && m_ds == 0) m_kind = K_ERR;
                    else if (m_err == 0 && m_ds == 0) m_kind = K_ABORT;
                    else                              m_kind = K_BAD;
                    m_act = pack(m_kind, int'(bus.beat), m_rd, m_busy);
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL burst_unexpected: got kind=%0d beat=%0d rd=%0d busy=%0d, none expected",
                                 m_kind, bus.beat, m_rd, m_busy);
                    end else begin
                        m_exp = exp_q.pop_front();
                        if (m_act != m_exp) begin
                            miscompares++;
                            $display("FAIL burst: got kind=%0d beat=%0d rd=%0d busy=%0d expected kind=%0d beat=%0d rd=%0d busy=%0d at %0t",
                                     m_act[21:20], m_act[19:16], m_act[15:8], m_act[7:0],
                                     m_exp[21:20], m_exp[19:16], m_exp[15:8], m_exp[7:0], $time);
                        end
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc_read();
        @(negedge clk);
        bus.go    = 1'($urandom_range(0, 1));
        bus.len   = CNT_W'($urandom_range(0, 15));
        bus.abort = 1'b0;
        bus.ws    = 1'($urandom_range(0, 1));
    endtask

    task automatic cyc_dly(input bit w, input bit ab);
        @(negedge clk);
        bus.go    = 1'($urandom_range(0, 1));
        bus.len   = CNT_W'($urandom_range(0, 15));
        bus.abort = ab;
        bus.ws    = w;
    endtask

    task automatic wait_idle(input int gap);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            bus.go    = 1'b0;
            bus.abort = 1'($urandom_range(0, 1));
            bus.ws    = 1'($urandom_range(0, 1));
            n++;
        end while (bus.busy && n < 8);
        if (bus.busy) begin
            vectors++;
            miscompares++;
            $display("FAIL idle_timeout: busy still %0d after %0d cycles, required 0", bus.busy, n);
        end
        repeat (gap) begin
            @(negedge clk);
            bus.go    = 1'b0;
            bus.abort = 1'($urandom_range(0, 1));
        end
        bus.abort = 1'b0;
    endtask

    task automatic run_burst(input int ln, input int ab_beat, input bit go_ab);
        int  n_beats;
        bit  ended;
        exp_q.push_back(model(ln, ab_beat));
        @(negedge clk);
        bus.go    = 1'b1;
        bus.len   = CNT_W'(ln);
        bus.abort = go_ab;
        bus.ws    = 1'($urandom_range(0, 1));
        n_beats = (ln == 0) ? 1 : ln;
        ended = 1'b0;
        for (int i = 0; i < n_beats && !ended; i++) begin
            for (int v = 0; ; v++) begin
                cyc_read();
                if (i == ab_beat) begin
                    cyc_dly(1'($urandom_range(0, 1)), 1'b1);
                    ended = 1'b1;
                    break;
                end
                if (v < waits[i]) begin
                    cyc_dly(1'b1, 1'b0);
                    if (v == MAX_WS) begin
                        ended = 1'b1;
                        break;
                    end
                end else begin
                    cyc_dly(1'b0, 1'b0);
                    break;
                end
            end
        end
        wait_idle($urandom_range(0, 2));
    endtask

    task automatic set_waits(input int w);
        for (int i = 0; i < 16; i++) waits[i] = w;
    endtask

    task automatic reset_mid_burst();
        set_waits(0);
        @(negedge clk);
        bus.go = 1'b1; bus.len = 4'd4; bus.abort = 1'b0; bus.ws = 1'b0;
        cyc_read();
        cyc_dly(1'b0, 1'b0);
        cyc_read();
        @(negedge clk);
        bus.go = 1'b0; bus.ws = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_rd",   int'(bus.rd),   0);
        check("rst_async_ds",   int'(bus.ds),   0);
        check("rst_async_err",  int'(bus.err),  0);
        check("rst_async_busy", int'(bus.busy), 0);
        check("rst_async_beat", int'(bus.beat), 0);
        repeat (2) @(negedge clk);
        bus.ws = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_beat", int'(bus.beat), 0);
        check("post_rst_busy", int'(bus.busy), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int ln, ab;
        bus.go = 1'b0; bus.len = '0; bus.ws = 1'b0; bus.abort = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_rd",    int'(bus.rd),   0);
        check("reset_ds",    int'(bus.ds),   0);
        check("reset_err",   int'(bus.err),  0);
        check("reset_busy",  int'(bus.busy), 0);
        check("reset_beat",  int'(bus.beat), 0);
        check("reset_onehot", $countones(bus.state), 1);
        rst_n = 1'b1;
        @(negedge clk);

        set_waits(0);  run_burst(1, -1, 1'b0);
        set_waits(0);  run_burst(3, -1, 1'b0);
        set_waits(5);  run_burst(2, -1, 1'b0);
        set_waits(0);  waits[0] = 2; run_burst(2, -1, 1'b0);
        set_waits(0);  run_burst(0, -1, 1'b0);
        set_waits(0);  run_burst(15, -1, 1'b0);
        set_waits(0);  run_burst(4, 1, 1'b0);
        set_waits(0);  run_burst(2, -1, 1'b1);
        set_waits(1);  run_burst(3, 0, 1'b0);

        reset_mid_burst();
        set_waits(0);  run_burst(2, -1, 1'b0);

        for (int t = 0; t < 40; t++) begin
            ln = $urandom_range(0, 15);
            for (int i = 0; i < 16; i++)
                waits[i] = ($urandom_range(0, 11) == 0) ? MAX_WS + 1 : $urandom_range(0, MAX_WS);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, (ln == 0) ? 0 : ln - 1) : -1;
            run_burst(ln, ab, 1'($urandom_range(0, 1)));
        end

        repeat (4) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
